// File: rtl/div_sched_pkg.sv
// Shared definitions for the div_sched arbitrated divider.
//   state_e : controller state encoding (IDLE=0, CHECK=1, ITER=2, DONE=3)
//   DVD_W   : dividend width, DVS_W : divisor width
//   N_ITER  : shift-subtract iterations per operation
package div_sched_pkg;

  localparam int unsigned DVD_W  = 8;
  localparam int unsigned DVS_W  = 4;
  localparam int unsigned N_ITER = 4;
  localparam int unsigned CNT_W  = $clog2(N_ITER);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_ITER  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/div_core.sv
// Restoring shift-subtract datapath: 8-bit working register X and 4-bit
// divisor Y.
//   clk, rst  : clock, asynchronous active-high reset
//   load_i    : capture dvd_i into X and dvs_i into Y
//   step_i    : perform one shift-subtract iteration on X
//   dvd_i     : dividend operand
//   dvs_i     : divisor operand
//   ovf_o     : divisor is zero or X[7:4] >= Y (quotient would not fit)
//   x_step_o  : value X takes after one iteration (result capture uses this)
module div_core
  import div_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [DVD_W-1:0] dvd_i,
  input  logic [DVS_W-1:0] dvs_i,
  output logic             ovf_o,
  output logic [DVD_W-1:0] x_step_o
);

  logic [DVD_W-1:0] x_q, x_d;
  logic [DVS_W-1:0] y_q, y_d;
  logic [DVS_W:0]   top;
  logic [DVS_W-1:0] diff;
  logic             ge;

  always_comb begin
    top  = x_q[DVD_W-1:DVS_W-1];
    ge   = (top >= {1'b0, y_q});
    // Once the overflow check passed, top - Y < Y whenever ge holds, so the
    // low bits of a narrow subtract already give the exact difference.
    diff = top[DVS_W-1:0] - y_q;
    x_step_o = ge ? {diff, x_q[DVS_W-2:0], 1'b1} : {x_q[DVD_W-2:0], 1'b0};
    ovf_o    = (y_q == '0) || (x_q[DVD_W-1:DVS_W] >= y_q);
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (load_i) begin
      x_d = dvd_i;
      y_d = dvs_i;
    end else if (step_i) begin
      x_d = x_step_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/div_sched.sv
// Two-requester round-robin arbiter in front of a shared 8/4 divider.
//   PRIO_RESET    : pointer after reset (0 = A first, 1 = B first)
//   clk, rst      : clock, asynchronous active-high reset
//   req_a/req_b   : level requests, held until the matching done pulse
//   dvd_*, dvs_*  : dividend / divisor of each requester
//   gnt_a/gnt_b   : current owner of the divider (never both, none in IDLE)
//   busy          : controller not in IDLE
//   done_a/done_b : one-cycle completion pulse for the owner
//   quot, rem, err: result of the last completed operation
module div_sched
  import div_sched_pkg::*;
#(
  parameter int unsigned PRIO_RESET = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [DVD_W-1:0] dvd_a,
  input  logic [DVS_W-1:0] dvs_a,
  input  logic             req_b,
  input  logic [DVD_W-1:0] dvd_b,
  input  logic [DVS_W-1:0] dvs_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             busy,
  output logic             done_a,
  output logic             done_b,
  output logic [DVS_W-1:0] quot,
  output logic [DVS_W-1:0] rem,
  output logic             err
);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;   // 1 = requester B
  logic             ptr_q, ptr_d;       // 1 = B preferred on a tie
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DVS_W-1:0] quot_q, quot_d, rem_q, rem_d;
  logic             err_q, err_d;
  logic             pick_b, load, step, ovf;
  logic [DVD_W-1:0] dvd_sel, x_step;
  logic [DVS_W-1:0] dvs_sel;

  assign dvd_sel = pick_b ? dvd_b : dvd_a;
  assign dvs_sel = pick_b ? dvs_b : dvs_a;

  div_core u_core (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .step_i   (step),
    .dvd_i    (dvd_sel),
    .dvs_i    (dvs_sel),
    .ovf_o    (ovf),
    .x_step_o (x_step)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    err_d   = err_q;
    load    = 1'b0;
    step    = 1'b0;
    pick_b  = req_b & (~req_a | ptr_q);
    case (state_q)
      S_IDLE: begin
        if (req_a || req_b) begin
          owner_d = pick_b;
          load    = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (ovf) begin
          quot_d  = '0;
          rem_d   = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d   = '0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        step  = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        // Result is taken from the final step's output on the same edge.
        if (cnt_q == CNT_W'(N_ITER - 1)) begin
          quot_d  = x_step[DVS_W-1:0];
          rem_d   = x_step[DVD_W-1:DVS_W];
          err_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        ptr_d   = ~owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      ptr_q   <= (PRIO_RESET != 0);
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign gnt_a  = busy & ~owner_q;
  assign gnt_b  = busy & owner_q;
  assign done_a = (state_q == S_DONE) & ~owner_q;
  assign done_b = (state_q == S_DONE) & owner_q;
  assign quot   = quot_q;
  assign rem    = rem_q;
  assign err    = err_q;

endmodule

// File: tb/tb_div_sched.sv
module tb_div_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [7:0] dvd_a = '0, dvd_b = '0;
  logic [3:0] dvs_a = '0, dvs_b = '0;
  logic       gnt_a, gnt_b, busy, done_a, done_b, err;
  logic [3:0] quot, rem;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] prev_q = '0, prev_r = '0;
  logic       prev_e = 1'b0;

  always #5 clk = ~clk;

  div_sched #(.PRIO_RESET(0)) dut (
    .clk    (clk),
    .rst    (rst),
    .req_a  (req_a),
    .dvd_a  (dvd_a),
    .dvs_a  (dvs_a),
    .req_b  (req_b),
    .dvd_b  (dvd_b),
    .dvs_b  (dvs_b),
    .gnt_a  (gnt_a),
    .gnt_b  (gnt_b),
    .busy   (busy),
    .done_a (done_a),
    .done_b (done_b),
    .quot   (quot),
    .rem    (rem),
    .err    (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; one request from A or B, checks latency and result.
  task automatic run_op(input string tag, input bit use_b, input logic [7:0] dvd,
                        input logic [3:0] dvs, input int exp_lat,
                        input logic [3:0] eq, input logic [3:0] er, input logic ee);
    int lat;
    lat = 0;
    if (use_b) begin req_b = 1'b1; dvd_b = dvd; dvs_b = dvs; end
    else       begin req_a = 1'b1; dvd_a = dvd; dvs_a = dvs; end
    @(posedge clk);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk({tag, "_busy"}, 32'(busy), 1);
        chk({tag, "_gnt_a"}, 32'(gnt_a), 32'(!use_b));
        chk({tag, "_gnt_b"}, 32'(gnt_b), 32'(use_b));
      end
      if (i == 1 || i == exp_lat - 1) begin
        chk({tag, "_hold_q"}, 32'(quot), 32'(prev_q));
        chk({tag, "_hold_r"}, 32'(rem), 32'(prev_r));
        chk({tag, "_hold_e"}, 32'(err), 32'(prev_e));
      end
      if (done_a || done_b) begin
        lat = i;
        chk({tag, "_done_owner"}, 32'(done_b), 32'(use_b));
        chk({tag, "_quot"}, 32'(quot), 32'(eq));
        chk({tag, "_rem"}, 32'(rem), 32'(er));
        chk({tag, "_err"}, 32'(err), 32'(ee));
        req_a = 1'b0;
        req_b = 1'b0;
        break;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    req_a = 1'b0;
    req_b = 1'b0;
    prev_q = eq;
    prev_r = er;
    prev_e = ee;
    @(negedge clk);
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    int ngr, ndone, overlap, spurious;
    logic prev_busy;

    // Asynchronous reset, observed before any clock edge
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gnt", 32'({gnt_a, gnt_b}), 0);
    chk("rst_done", 32'({done_a, done_b}), 0);
    chk("rst_quot", 32'(quot), 0);
    chk("rst_rem", 32'(rem), 0);
    chk("rst_err", 32'(err), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Both request together from reset: grants alternate A,B,A,B
    req_a = 1'b1; dvd_a = 8'd135; dvs_a = 4'd11;
    req_b = 1'b1; dvd_b = 8'd127; dvs_b = 4'd15;
    ngr = 0; ndone = 0; overlap = 0; prev_busy = 1'b0;
    for (int c = 0; c < 80 && ndone < 4; c++) begin
      @(negedge clk);
      if ((gnt_a && gnt_b) || (!busy && (gnt_a || gnt_b))) overlap++;
      if (busy && !prev_busy) begin
        chk("arb_grant_b", 32'(gnt_b), 32'(ngr % 2));
        chk("arb_grant_a", 32'(gnt_a), 32'((ngr + 1) % 2));
        ngr++;
      end
      prev_busy = busy;
      if (done_a) begin
        chk("arb_a_quot", 32'(quot), 12);
        chk("arb_a_rem", 32'(rem), 3);
        ndone++;
      end
      if (done_b) begin
        chk("arb_b_quot", 32'(quot), 8);
        chk("arb_b_rem", 32'(rem), 7);
        ndone++;
      end
    end
    req_a = 1'b0;
    req_b = 1'b0;
    chk("arb_done_count", 32'(ndone), 4);
    chk("arb_grant_count", 32'(ngr), 4);
    chk("arb_gnt_exclusive", 32'(overlap), 0);
    prev_q = 4'd8; prev_r = 4'd7; prev_e = 1'b0;
    @(negedge clk);

    // Single-requester directed operations
    run_op("a_135_11", 1'b0, 8'd135, 4'd11, 6, 4'd12, 4'd3, 1'b0);
    run_op("b_7_0",    1'b1, 8'd7,   4'd0,  2, 4'd0,  4'd0, 1'b1);
    run_op("a_200_5",  1'b0, 8'd200, 4'd5,  2, 4'd0,  4'd0, 1'b1);
    run_op("a_0_7",    1'b0, 8'd0,   4'd7,  6, 4'd0,  4'd0, 1'b0);
    run_op("a_255_15", 1'b0, 8'd255, 4'd15, 2, 4'd0,  4'd0, 1'b1);
    run_op("a_127_15", 1'b0, 8'd127, 4'd15, 6, 4'd8,  4'd7, 1'b0);
    run_op("b_100_9",  1'b1, 8'd100, 4'd9,  6, 4'd11, 4'd1, 1'b0);

    // Reset in the second ITER cycle discards the operation
    req_a = 1'b1; dvd_a = 8'd135; dvs_a = 4'd11;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_pre_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_gnt_a", 32'(gnt_a), 0);
    chk("midrst_done", 32'({done_a, done_b}), 0);
    chk("midrst_quot", 32'(quot), 0);
    chk("midrst_rem", 32'(rem), 0);
    req_a = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done_a || done_b || busy) spurious++;
    end
    chk("midrst_no_done", 32'(spurious), 0);
    prev_q = '0; prev_r = '0; prev_e = 1'b0;
    run_op("after_rst", 1'b0, 8'd135, 4'd11, 6, 4'd12, 4'd3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 Parameter PRIO_RESET, default 0, round-robin pointer value after reset (0 = requester A first, 1 = requester B first).
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req_a  input  1  requester A request, level; held high until done_a.
REQ-005 dvd_a  input  8  requester A dividend; stable while req_a is high.
REQ-006 dvs_a  input  4  requester A divisor; stable while req_a is high.
REQ-007 req_b  input  1  requester B request; same rules as req_a.
REQ-008 dvd_b  input  8  requester B dividend.
REQ-009 dvs_b  input  4  requester B divisor.
REQ-010 gnt_a  output  1  high while A owns the divider (CHECK, ITER, DONE).
REQ-011 gnt_b  output  1  high while B owns the divider.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done_a  output  1  one-cycle pulse in DONE when the owner is A.
REQ-014 done_b  output  1  one-cycle pulse in DONE when the owner is B.
REQ-015 quot  output  4  quotient of the last completed operation; held until the next DONE.
REQ-016 rem  output  4  remainder of the last completed operation; held until the next DONE.
REQ-017 err  output  1  error flag of the last completed operation; held until the next DONE.

Function
REQ-018 FSM states are IDLE, CHECK, ITER and DONE.
REQ-019 IDLE with a single request: grant that requester.
REQ-020 IDLE with both requests: grant the requester selected by the pointer.
REQ-021 On the grant edge, latch the granted operands into the core, record the owner, and enter CHECK.
REQ-022 IDLE with no request: remain in IDLE.
REQ-023 CHECK, divisor == 0 or dividend[7:4] >= divisor (quotient overflow): set err=1, quot=0, rem=0, enter DONE.
REQ-024 CHECK, otherwise: enter ITER with the iteration counter at 0.
REQ-025 ITER runs exactly 4 cycles of restoring shift-subtract on the 8-bit working register X and 4-bit divisor Y.
REQ-026 Each ITER cycle, if X[7:3] >= Y (5-bit compare): X[7:4] <= (X[7:3]-Y)[3:0] and X[3:0] <= {X[2:0],1}.
REQ-027 Each ITER cycle, otherwise: X <= {X[6:0],0}.
REQ-028 After the 4th ITER cycle, enter DONE.
REQ-029 Entering DONE: quot <= X[3:0], rem <= X[7:4], err <= 0.
REQ-030 DONE lasts one cycle: pulse done for the owner, toggle the pointer to the other requester, return to IDLE.
REQ-031 Latency, request sampled in IDLE at edge N: done pulse asserted in cycle N+6 (normal) or N+2 (error).
REQ-032 A request still high in the IDLE cycle after DONE is a new request and arbitrates normally; a requester cannot be granted twice in a row while the other is waiting.
REQ-033 A request that falls while its owner is busy is ignored; the operation completes and done still pulses.
REQ-034 gnt_a and gnt_b are never high together; neither is high in IDLE.

Reset
REQ-035 Reset forces IDLE immediately, including mid-ITER; the in-flight result is discarded with no done pulse.
REQ-036 Reset values: busy, gnt_a, gnt_b, done_a, done_b, err = 0; quot, rem, X, Y, iteration counter = 0; pointer = PRIO_RESET.

Structure
REQ-037 A shared package holds the state encoding (IDLE=0, CHECK=1, ITER=2, DONE=3), the widths DVD_W=8 and DVS_W=4, and the iteration count 4.
REQ-038 The shift-subtract datapath (X, Y, comparator, subtractor, load/step controls) is one sub-module, div_core; arbitration and the FSM stay in div_sched.

Verification
REQ-039 req_a with 135/11 -> done_a at N+6, quot=12, rem=3, err=0.
REQ-040 req_b with 7/0 -> done_b at N+2, err=1, quot=0, rem=0.
REQ-041 req_a with 200/5 (overflow) -> done_a at N+2, err=1; also 0/7 -> quot=0, rem=0, err=0.
REQ-042 req_a and req_b rise together and both stay high, PRIO_RESET=0 -> A served first, then B; grants alternate A,B,A,B.
REQ-043 rst asserted in the 2nd ITER cycle -> busy=0 immediately, no done pulse, quot/rem=0; the next request completes correctly.
REQ-044 req_a with 255/15 -> err=1; 127/15 -> quot=8, rem=7; the previous quot/rem hold until each done pulse.
